// File: rtl/blade_sequencer.sv
// rtl/blade_sequencer.sv - lightsaber blade length sequencer with ignite/resize/retract ramps
// Optional feature macro: BLADE_INSTANT_RETRACT_EN (retract drops the blade to 0 in one cycle)
module blade_sequencer #(
    parameter int STEP_CM  = 5,
    parameter int TICK_DIV = 4,
    parameter int MAX_CM   = 100,
    parameter int DEF_CM   = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ignite,
    input  logic        retract,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [15:0] cfg_L,
    input  logic [15:0] cfg_R,
    input  logic [1:0]  cfg_blade,
    output logic [15:0] blade_L,
    output logic [15:0] blade_R,
    output logic [15:0] hilt_len,
    output logic        blade_on,
    output logic        busy,
    output logic [2:0]  state,
    output logic        err
);

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_IGNITE  = 3'd1;
    localparam logic [2:0] S_ON      = 3'd2;
    localparam logic [2:0] S_RESIZE  = 3'd3;
    localparam logic [2:0] S_RETRACT = 3'd4;

    localparam logic [7:0]         STEP8     = 8'(STEP_CM);
    localparam logic [7:0]         DEF8      = 8'(DEF_CM);
    localparam logic [7:0]         MAX8      = 8'(MAX_CM);
    localparam logic signed [31:0] MAX32     = 32'(MAX_CM);
    localparam logic [15:0]        TICK_LAST = 16'(TICK_DIV - 1);

    logic [7:0]  cur_cm;
    logic [7:0]  tgt_cm;
    logic [1:0]  bcfg;
    logic [15:0] tick;

    assign cfg_ready = (state == S_OFF) || (state == S_ON);
    assign blade_on  = (state == S_ON);
    assign busy      = (state == S_IGNITE) || (state == S_RESIZE) || (state == S_RETRACT);
    assign blade_L   = {15'd0, (cur_cm >= 8'd100)};
    assign blade_R   = {8'd0, (cur_cm >= 8'd100) ? (cur_cm - 8'd100) : cur_cm};
    assign hilt_len  = (bcfg == 2'd3) ? 16'd10 : 16'd0;

    // Requested length in signed cm; sign-extended so negative metres stay negative.
    logic signed [31:0] req;
    logic               cfg_take;
    logic               cfg_bad;
    logic [7:0]         new_tgt;
    logic [1:0]         new_bcfg;

    assign req      = $signed({{16{cfg_L[15]}}, cfg_L}) * 32'sd100 + $signed({{16{cfg_R[15]}}, cfg_R});
    assign cfg_take = cfg_valid && cfg_ready;

    always_comb begin
        new_tgt  = tgt_cm;
        new_bcfg = bcfg;
        cfg_bad  = 1'b0;
        if (cfg_blade == 2'd0) begin
            cfg_bad = 1'b1;
        end else begin
            new_bcfg = cfg_blade;
            if (cfg_L[15] || cfg_R[15] || (req == 32'sd0)) begin
                new_tgt = DEF8;
                cfg_bad = 1'b1;
            end else if (req > MAX32) begin
                new_tgt = MAX8;
                cfg_bad = 1'b1;
            end else begin
                new_tgt = req[7:0];
            end
        end
    end

    // One saturating step toward the destination; retract always heads for zero.
    logic [7:0] dest;
    logic [7:0] diff;
    logic [7:0] delta;
    logic [7:0] stepped;
    logic       going_up;
    logic       step_fire;

    always_comb begin
        dest     = (state == S_RETRACT) ? 8'd0 : tgt_cm;
        going_up = (dest > cur_cm);
        diff     = going_up ? (dest - cur_cm) : (cur_cm - dest);
        delta    = (diff < STEP8) ? diff : STEP8;
        stepped  = going_up ? (cur_cm + delta) : (cur_cm - delta);
    end

    assign step_fire = (tick == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_OFF;
            cur_cm <= 8'd0;
            tgt_cm <= DEF8;
            bcfg   <= 2'd1;
            tick   <= 16'd0;
            err    <= 1'b0;
        end else begin
            err <= cfg_take && cfg_bad;
            if (cfg_take) begin
                tgt_cm <= new_tgt;
                bcfg   <= new_bcfg;
            end
            case (state)
                S_OFF: begin
                    tick <= 16'd0;
                    if (ignite && !retract) begin
                        state <= S_IGNITE;
                    end
                end
                S_IGNITE, S_RESIZE: begin
                    if (retract) begin
                        state <= S_RETRACT;
                        tick  <= 16'd0;
                    end else if (step_fire) begin
                        cur_cm <= stepped;
                        tick   <= 16'd0;
                        if (stepped == dest) begin
                            state <= S_ON;
                        end
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_ON: begin
                    tick <= 16'd0;
                    if (retract) begin
                        state <= S_RETRACT;
                    end else if (cfg_take && (new_tgt != cur_cm)) begin
                        state <= S_RESIZE;
                    end
                end
                S_RETRACT: begin
`ifdef BLADE_INSTANT_RETRACT_EN
                    cur_cm <= 8'd0;
                    tick   <= 16'd0;
                    state  <= S_OFF;
`else
                    if (step_fire) begin
                        cur_cm <= stepped;
                        tick   <= 16'd0;
                        if (stepped == 8'd0) begin
                            state <= S_OFF;
                        end
                    end else begin
                        tick <= tick + 16'd1;
                    end
`endif
                end
                default: begin
                    state <= S_OFF;
                    tick  <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blade_sequencer.sv
// tb/tb_blade_sequencer.sv - directed self-checking bench for blade_sequencer
module tb_blade_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ignite;
    logic        retract;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_L;
    logic [15:0] cfg_R;
    logic [1:0]  cfg_blade;
    logic [15:0] blade_L;
    logic [15:0] blade_R;
    logic [15:0] hilt_len;
    logic        blade_on;
    logic        busy;
    logic [2:0]  state;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    blade_sequencer #(.STEP_CM(5), .TICK_DIV(4), .MAX_CM(100), .DEF_CM(50)) dut (
        .clk(clk), .rst(rst), .ignite(ignite), .retract(retract),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_L(cfg_L), .cfg_R(cfg_R),
        .cfg_blade(cfg_blade), .blade_L(blade_L), .blade_R(blade_R), .hilt_len(hilt_len),
        .blade_on(blade_on), .busy(busy), .state(state), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ignite();
        ignite = 1'b1;
        tick_n(1);
        ignite = 1'b0;
    endtask

    task automatic pulse_retract();
        retract = 1'b1;
        tick_n(1);
        retract = 1'b0;
    endtask

    task automatic offer_cfg(input logic [15:0] l, input logic [15:0] r, input logic [1:0] b);
        cfg_valid = 1'b1;
        cfg_L     = l;
        cfg_R     = r;
        cfg_blade = b;
        tick_n(1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output int cycles);
        cycles = 0;
        while (state !== s && cycles < budget) begin
            tick_n(1);
            cycles++;
        end
    endtask

    task automatic test_reset();
        #23;
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state); end
        n_cmp++; if (blade_L !== 16'd0 || blade_R !== 16'd0) begin n_bad++; $display("FAIL reset_blade got %0d.%0d want 0.0", blade_L, blade_R); end
        n_cmp++; if (hilt_len !== 16'd0) begin n_bad++; $display("FAIL reset_hilt got %0d want 0", hilt_len); end
        n_cmp++; if (blade_on !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_flags got on=%0b busy=%0b err=%0b want 0 0 0", blade_on, busy, err); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cfg_ready got %0b want 1", cfg_ready); end
        #4 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignite();
        pulse_ignite();
        n_cmp++; if (state !== 3'd1 || busy !== 1'b1) begin n_bad++; $display("FAIL ignite_entry got state=%0d busy=%0b want 1 1", state, busy); end
        for (int k = 1; k <= 10; k++) begin
            tick_n(3);
            n_cmp++; if (blade_R !== 16'(5 * (k - 1))) begin n_bad++; $display("FAIL ignite_hold%0d got %0d want %0d", k, blade_R, 5 * (k - 1)); end
            tick_n(1);
            n_cmp++; if (blade_R !== 16'(5 * k)) begin n_bad++; $display("FAIL ignite_step%0d got %0d want %0d", k, blade_R, 5 * k); end
        end
        n_cmp++; if (state !== 3'd2 || blade_on !== 1'b1 || blade_L !== 16'd0) begin n_bad++; $display("FAIL ignite_on got state=%0d on=%0b L=%0d want 2 1 0", state, blade_on, blade_L); end
    endtask

    task automatic test_resize();
        int cyc;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL on_cfg_ready got %0b want 1", cfg_ready); end
        offer_cfg(16'd1, 16'd0, 2'd2);
        n_cmp++; if (state !== 3'd3 || err !== 1'b0 || cfg_ready !== 1'b0) begin n_bad++; $display("FAIL resize_entry got state=%0d err=%0b rdy=%0b want 3 0 0", state, err, cfg_ready); end
        for (int k = 1; k <= 10; k++) begin
            tick_n(4);
            n_cmp++; if (blade_L * 100 + blade_R !== 16'(50 + 5 * k)) begin n_bad++; $display("FAIL resize_up%0d got %0d.%0d want %0d cm", k, blade_L, blade_R, 50 + 5 * k); end
        end
        n_cmp++; if (state !== 3'd2 || blade_L !== 16'd1 || blade_R !== 16'd0) begin n_bad++; $display("FAIL resize_up_end got state=%0d %0d.%0d want 2 1.0", state, blade_L, blade_R); end
        offer_cfg(16'd0, 16'd80, 2'd2);
        n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL resize_down_entry got %0d want 3", state); end
        for (int k = 1; k <= 4; k++) begin
            tick_n(4);
            n_cmp++; if (blade_L * 100 + blade_R !== 16'(100 - 5 * k)) begin n_bad++; $display("FAIL resize_down%0d got %0d.%0d want %0d cm", k, blade_L, blade_R, 100 - 5 * k); end
        end
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL resize_down_end got %0d want 2", state); end
        pulse_retract();
        n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL retract_entry got %0d want 4", state); end
        wait_state(3'd0, 200, cyc);
        n_cmp++; if (state !== 3'd0 || blade_R !== 16'd0) begin n_bad++; $display("FAIL retract_off got state=%0d R=%0d want 0 0", state, blade_R); end
    endtask

    task automatic test_cfg_validation();
        int cyc;
        offer_cfg(16'd0, 16'd120, 2'd1);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL clamp_err got %0b want 1", err); end
        tick_n(1);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL clamp_err_pulse got %0b want 0", err); end
        pulse_ignite();
        wait_state(3'd2, 120, cyc);
        n_cmp++; if (state !== 3'd2 || blade_L !== 16'd1 || blade_R !== 16'd0 || cyc !== 80) begin n_bad++; $display("FAIL clamp_target got state=%0d %0d.%0d cyc=%0d want 2 1.0 80", state, blade_L, blade_R, cyc); end
        pulse_retract();
        wait_state(3'd0, 200, cyc);
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL clamp_retract got %0d want 0", state); end
        offer_cfg(16'hFFFF, 16'd0, 2'd1);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL neg_err got %0b want 1", err); end
        tick_n(1);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL neg_err_pulse got %0b want 0", err); end
        offer_cfg(16'd0, 16'd30, 2'd0);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL reject_err got %0b want 1", err); end
        pulse_ignite();
        wait_state(3'd2, 120, cyc);
        n_cmp++; if (blade_L !== 16'd0 || blade_R !== 16'd50 || cyc !== 40) begin n_bad++; $display("FAIL default_target got %0d.%0d cyc=%0d want 0.50 40", blade_L, blade_R, cyc); end
        pulse_retract();
        wait_state(3'd0, 200, cyc);
    endtask

    task automatic test_retract();
        int cyc;
        ignite  = 1'b1;
        retract = 1'b1;
        tick_n(1);
        ignite  = 1'b0;
        retract = 1'b0;
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL ignite_retract_same got %0d want 0", state); end
        pulse_ignite();
        cyc = 0;
        while (blade_R !== 16'd25 && cyc < 50) begin
            tick_n(1);
            cyc++;
        end
        n_cmp++; if (blade_R !== 16'd25 || state !== 3'd1) begin n_bad++; $display("FAIL reach_25 got R=%0d state=%0d want 25 1", blade_R, state); end
        pulse_retract();
        n_cmp++; if (state !== 3'd4 || blade_R !== 16'd25) begin n_bad++; $display("FAIL midramp_retract got state=%0d R=%0d want 4 25", state, blade_R); end
`ifdef BLADE_INSTANT_RETRACT_EN
        tick_n(1);
        n_cmp++; if (blade_R !== 16'd0 || state !== 3'd0) begin n_bad++; $display("FAIL instant_retract got R=%0d state=%0d want 0 0", blade_R, state); end
`else
        for (int k = 1; k <= 5; k++) begin
            tick_n(4);
            n_cmp++; if (blade_R !== 16'(25 - 5 * k)) begin n_bad++; $display("FAIL retract_step%0d got %0d want %0d", k, blade_R, 25 - 5 * k); end
        end
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL retract_done got %0d want 0", state); end
`endif
    endtask

    task automatic test_hilt();
        offer_cfg(16'd0, 16'd42, 2'd3);
        n_cmp++; if (hilt_len !== 16'd10 || err !== 1'b0) begin n_bad++; $display("FAIL hilt_on got hilt=%0d err=%0b want 10 0", hilt_len, err); end
        offer_cfg(16'd0, 16'd42, 2'd1);
        n_cmp++; if (hilt_len !== 16'd0) begin n_bad++; $display("FAIL hilt_off got %0d want 0", hilt_len); end
    endtask

    task automatic test_reset_mid_resize();
        int cyc;
        pulse_ignite();
        wait_state(3'd2, 120, cyc);
        n_cmp++; if (blade_R !== 16'd42 || cyc !== 36) begin n_bad++; $display("FAIL saturate_42 got R=%0d cyc=%0d want 42 36", blade_R, cyc); end
        offer_cfg(16'd0, 16'd90, 2'd1);
        tick_n(6);
        n_cmp++; if (state !== 3'd3 || blade_R !== 16'd47) begin n_bad++; $display("FAIL pre_reset got state=%0d R=%0d want 3 47", state, blade_R); end
        #3 rst = 1'b0;
        #1;
        n_cmp++; if (state !== 3'd0 || blade_L !== 16'd0 || blade_R !== 16'd0 || blade_on !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL async_reset got state=%0d %0d.%0d on=%0b busy=%0b want 0 0.0 0 0", state, blade_L, blade_R, blade_on, busy); end
        #2 rst = 1'b1;
        tick_n(1);
        pulse_ignite();
        wait_state(3'd2, 120, cyc);
        n_cmp++; if (blade_R !== 16'd50 || cyc !== 40) begin n_bad++; $display("FAIL post_reset_ignite got R=%0d cyc=%0d want 50 40", blade_R, cyc); end
    endtask

    initial begin
        rst       = 1'b0;
        ignite    = 1'b0;
        retract   = 1'b0;
        cfg_valid = 1'b0;
        cfg_L     = 16'd0;
        cfg_R     = 16'd0;
        cfg_blade = 2'd1;
        test_reset();
        test_ignite();
        test_resize();
        test_cfg_validation();
        test_retract();
        test_hilt();
        test_reset_mid_resize();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
